// File: rtl/bcd_entry_buffer.sv
// bcd_entry_buffer: calculator-style BCD digit-entry buffer.
// Digits shift in at the least-significant position. The buffer supports
// backspace, clear and commit; a commit copies the entry to a holding
// register and pulses out_valid for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key_valid  digit strobe, key_code holds the digit (valid BCD 0..9)
//   bksp       delete the newest digit
//   clr        discard the entry
//   commit     transfer the entry to out
//   entry      live entry, packed BCD, digit 0 in [3:0]
//   count      number of digits entered, 0..NUM_DIGITS
//   full       count == NUM_DIGITS (combinational)
//   out        last committed value, packed BCD
//   out_valid  one-cycle pulse when out is updated
//   err        one-cycle pulse when a key is rejected
module bcd_entry_buffer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1),
    parameter bit          AUTO_CLEAR = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    bksp,
    input  logic                    clr,
    input  logic                    commit,
    output logic [4*NUM_DIGITS-1:0] entry,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic [4*NUM_DIGITS-1:0] out,
    output logic                    out_valid,
    output logic                    err
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [DATA_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    logic empty_w;
    logic full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(NUM_DIGITS));

    // Next-state: one request acts per cycle, clr > commit > bksp > key_valid.
    always_comb begin
        entry_d     = entry_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        if (clr) begin
            entry_d = '0;
            count_d = '0;
        end else if (commit) begin
            if (!empty_w) begin
                out_d       = entry_q;
                out_valid_d = 1'b1;
                if (AUTO_CLEAR) begin
                    entry_d = '0;
                    count_d = '0;
                end
            end
        end else if (bksp) begin
            if (!empty_w) begin
                entry_d = {4'h0, entry_q[DATA_W-1:4]};
                count_d = count_q - CNT_W'(1);
            end
        end else if (key_valid) begin
            // Non-BCD codes and keys on a full buffer are rejected; the MSD never shifts out.
            if ((key_code > 4'd9) || full_w) begin
                err_d = 1'b1;
            end else begin
                entry_d = {entry_q[DATA_W-5:0], key_code};
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset overrides any strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q     <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign entry     = entry_q;
    assign count     = count_q;
    assign full      = full_w;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry_buffer.sv
// Scoreboard bench for bcd_entry_buffer. Three instances share one stimulus
// stream: (4 digits, auto-clear), (4 digits, retain), (2 digits, auto-clear).
// A digit-list model predicts each instance; the monitor compares every cycle
// and pops committed values whenever out_valid is seen.
module tb_bcd_entry_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, key_valid = 1'b0, bksp = 1'b0, clr = 1'b0, commit = 1'b0;
    logic [3:0] key_code = 4'h0;

    logic [15:0] e0, o0, e1, o1;
    logic [7:0]  e2, o2;
    logic [2:0]  c0, c1;
    logic [1:0]  c2;
    logic        f0, f1, f2, v0, v1, v2, r0, r1, r2;

    bcd_entry_buffer #(.NUM_DIGITS(4), .AUTO_CLEAR(1'b1)) u0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .bksp(bksp),
        .clr(clr), .commit(commit), .entry(e0), .count(c0), .full(f0), .out(o0),
        .out_valid(v0), .err(r0));
    bcd_entry_buffer #(.NUM_DIGITS(4), .AUTO_CLEAR(1'b0)) u1 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .bksp(bksp),
        .clr(clr), .commit(commit), .entry(e1), .count(c1), .full(f1), .out(o1),
        .out_valid(v1), .err(r1));
    bcd_entry_buffer #(.NUM_DIGITS(2), .AUTO_CLEAR(1'b1)) u2 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .bksp(bksp),
        .clr(clr), .commit(commit), .entry(e2), .count(c2), .full(f2), .out(o2),
        .out_valid(v2), .err(r2));

    typedef struct packed {
        logic [2:0][31:0] entry;
        logic [2:0][31:0] outv;
        logic [2:0][3:0]  cnt;
        logic [2:0]       full;
        logic [2:0]       ov;
        logic [2:0]       err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned oq0[$], oq1[$], oq2[$];

    // Model: per instance a list of typed digits, dig[k][0] is the newest.
    int unsigned dig[3][8];
    int          len[3];
    int unsigned mout[3];

    int checks = 0;
    int passed = 0;

    function automatic int nd(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic bit auto_clr(input int k);
        return (k != 1);
    endfunction

    function automatic int unsigned value(input int k);
        int unsigned v = 0;
        for (int i = 0; i < len[k]; i++) v += dig[k][i] * (32'd1 << (4 * i));
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv)
            $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, k, $time, act, expv);
        else
            passed++;
    endtask

    task automatic push_out(input int k, input int unsigned v);
        case (k)
            0: oq0.push_back(v);
            1: oq1.push_back(v);
            default: oq2.push_back(v);
        endcase
    endtask

    task automatic pop_out(input int k, output int unsigned v, output bit ok);
        ok = 1'b1;
        v  = 0;
        case (k)
            0: if (oq0.size() > 0) v = oq0.pop_front(); else ok = 1'b0;
            1: if (oq1.size() > 0) v = oq1.pop_front(); else ok = 1'b0;
            default: if (oq2.size() > 0) v = oq2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Drive one cycle of strobes and record what each instance should show after the edge.
    task automatic step(input bit r, input bit kv, input logic [3:0] kc,
                        input bit bk, input bit cl, input bit cm);
        exp_t x;
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc; bksp = bk; clr = cl; commit = cm;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                len[k]  = 0;
                mout[k] = 0;
            end else if (cl) begin
                len[k] = 0;
            end else if (cm) begin
                if (len[k] > 0) begin
                    mout[k] = value(k);
                    x.ov[k] = 1'b1;
                    push_out(k, mout[k]);
                    if (auto_clr(k)) len[k] = 0;
                end
            end else if (bk) begin
                if (len[k] > 0) begin
                    for (int i = 0; i < 7; i++) dig[k][i] = dig[k][i+1];
                    dig[k][7] = 0;
                    len[k]--;
                end
            end else if (kv) begin
                if (kc > 4'd9 || len[k] == nd(k)) begin
                    x.err[k] = 1'b1;
                end else begin
                    for (int i = 7; i > 0; i--) dig[k][i] = dig[k][i-1];
                    dig[k][0] = 32'(kc);
                    len[k]++;
                end
            end
            x.entry[k] = value(k);
            x.outv[k]  = mout[k];
            x.cnt[k]   = 4'(len[k]);
            x.full[k]  = (len[k] == nd(k));
        end
        exp_q.push_back(x);
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b0, 1'b1, kc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare registered outputs one tick after each rising edge.
    initial begin
        exp_t        x;
        logic [31:0] ae[3], ao[3], ac[3];
        logic        af[3], av[3], ar[3];
        int unsigned ov;
        bit          ok;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                ae[0] = 32'(e0); ae[1] = 32'(e1); ae[2] = 32'(e2);
                ao[0] = 32'(o0); ao[1] = 32'(o1); ao[2] = 32'(o2);
                ac[0] = 32'(c0); ac[1] = 32'(c1); ac[2] = 32'(c2);
                af[0] = f0; af[1] = f1; af[2] = f2;
                av[0] = v0; av[1] = v1; av[2] = v2;
                ar[0] = r0; ar[1] = r1; ar[2] = r2;
                for (int k = 0; k < 3; k++) begin
                    chk("entry", k, ae[k], x.entry[k]);
                    chk("count", k, ac[k], 32'(x.cnt[k]));
                    chk("full", k, 32'(af[k]), 32'(x.full[k]));
                    chk("err", k, 32'(ar[k]), 32'(x.err[k]));
                    chk("out_valid", k, 32'(av[k]), 32'(x.ov[k]));
                    chk("out_hold", k, ao[k], x.outv[k]);
                    if (av[k] === 1'b1) begin
                        pop_out(k, ov, ok);
                        if (!ok) chk("out_valid_unexpected", k, 32'd1, 32'd0);
                        else     chk("out_commit", k, ao[k], ov);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            len[k] = 0; mout[k] = 0;
            for (int i = 0; i < 8; i++) dig[k][i] = 0;
        end

        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        idle();
        key(4'd1); key(4'd2); key(4'd3);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        key(4'hA);
        key(4'd4); key(4'd5);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        key(4'd4); key(4'd2);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        key(4'd3);
        step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        key(4'd5); key(4'd6);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        key(4'd1); key(4'd2);
        step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle();
        key(4'd1); key(4'd2); key(4'd3);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            logic [3:0] kc;
            kc = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, kc,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 10);
        end
        idle();
        @(negedge clk);
        @(negedge clk);

        chk("out_queue_drained", 0, 32'(oq0.size()), 32'd0);
        chk("out_queue_drained", 1, 32'(oq1.size()), 32'd0);
        chk("out_queue_drained", 2, 32'(oq2.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
